// File: rtl/led_count_allocator_if.sv
// rtl/led_count_allocator_if.sv - request/result bundle between a requester and the LED count allocator
interface led_count_allocator_if #(
  parameter int W       = 6,
  parameter int D       = 10,
  parameter int LEDS    = 50,
  parameter int BIN_QTY = 12
);
  localparam int AW = W + D;
  localparam int CW = $clog2(LEDS);

  logic                        start;
  logic [BIN_QTY-1:0][AW-1:0]  noteAmplitudes;
  logic [BIN_QTY-1:0][CW-1:0]  LEDCounts;
  logic                        data_v;
  logic                        busy;

  modport master (output start, noteAmplitudes, input LEDCounts, data_v, busy);
  modport slave  (input start, noteAmplitudes, output LEDCounts, data_v, busy);
endinterface

// File: rtl/led_count_allocator.sv
// rtl/led_count_allocator.sv - splits LEDS LEDs across note bins in proportion to amplitude
module led_count_allocator #(
  parameter int W       = 6,
  parameter int D       = 10,
  parameter int LEDS    = 50,
  parameter int BIN_QTY = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  led_count_allocator_if.slave bus
);
  localparam int AW = W + D;
  localparam int QB = $clog2(LEDS + 1);
  localparam int CW = $clog2(LEDS);
  localparam int IW = $clog2(BIN_QTY);
  localparam int SW = AW + IW;
  localparam int NW = AW + QB;
  localparam int TW = QB + IW;
  localparam int PW = $clog2(QB + 1);

  typedef enum logic [2:0] {IDLE, SUM, DIV, FIX, DONE} state_t;

  state_t                      state, state_nx;
  logic [BIN_QTY-1:0][AW-1:0]  amp;
  logic [SW-1:0]               sum;
  logic [AW-1:0]               max_val;
  logic [IW-1:0]               max_idx;
  logic [IW-1:0]               idx;
  logic [PW-1:0]               phase;
  logic [SW-1:0]               rem;
  logic [QB-1:0]               low;
  logic [QB-1:0]               quo;
  logic [BIN_QTY-1:0][QB-1:0]  cnt;
  logic [TW-1:0]               total;
  logic [BIN_QTY-1:0][CW-1:0]  led_counts;
  logic                        data_v_q;

  logic [AW-1:0]               amp_cur;
  logic [SW-1:0]               sum_nx;
  logic [NW-1:0]               num;
  logic [SW:0]                 trial;
  logic [SW:0]                 trial_sub;
  logic                        take;
  logic [QB-1:0]               quo_nx;
  logic [TW-1:0]               fix_val;
  logic                        last_bin;
  logic                        last_phase;

  // Quotient never exceeds LEDS < 2**QB, so the top AW bits of the numerator
  // are already below sum and only QB restoring steps are needed.
  always_comb begin
    amp_cur    = amp[idx];
    sum_nx     = sum + SW'(amp_cur);
    num        = NW'(amp_cur) * NW'(LEDS);
    trial      = {rem, low[QB-1]};
    trial_sub  = trial - {1'b0, sum};
    take       = (trial >= {1'b0, sum});
    quo_nx     = {quo[QB-2:0], take};
    fix_val    = TW'(cnt[max_idx]) + TW'(LEDS) - total;
    last_bin   = (idx == IW'(BIN_QTY - 1));
    last_phase = (phase == PW'(QB));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.start) state_nx = SUM;
      SUM:  if (last_bin) state_nx = (sum_nx == '0) ? DONE : DIV;
      DIV:  if (last_bin && last_phase) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      amp        <= '0;
      sum        <= '0;
      max_val    <= '0;
      max_idx    <= '0;
      idx        <= '0;
      phase      <= '0;
      rem        <= '0;
      low        <= '0;
      quo        <= '0;
      cnt        <= '0;
      total      <= '0;
      led_counts <= '0;
      data_v_q   <= 1'b0;
    end else begin
      data_v_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            amp     <= bus.noteAmplitudes;
            sum     <= '0;
            max_val <= '0;
            max_idx <= '0;
            idx     <= '0;
            phase   <= '0;
            cnt     <= '0;
            total   <= '0;
          end
        end
        SUM: begin
          sum <= sum_nx;
          // Strict compare keeps the lowest index on ties
          if (amp_cur > max_val) begin
            max_val <= amp_cur;
            max_idx <= idx;
          end
          if (last_bin) begin
            idx   <= '0;
            phase <= '0;
            if (sum_nx == '0) begin
              led_counts <= '0;
              data_v_q   <= 1'b1;
            end
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DIV: begin
          if (phase == '0) begin
            rem   <= SW'(num[NW-1:QB]);
            low   <= num[QB-1:0];
            quo   <= '0;
            phase <= phase + 1'b1;
          end else begin
            rem <= take ? trial_sub[SW-1:0] : trial[SW-1:0];
            low <= low << 1;
            quo <= quo_nx;
            if (last_phase) begin
              cnt[idx] <= quo_nx;
              total    <= total + TW'(quo_nx);
              phase    <= '0;
              idx      <= last_bin ? '0 : idx + 1'b1;
            end else begin
              phase <= phase + 1'b1;
            end
          end
        end
        FIX: begin
          for (int i = 0; i < BIN_QTY; i++)
            led_counts[i] <= (IW'(i) == max_idx) ? fix_val[CW-1:0] : CW'(cnt[i]);
          data_v_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.LEDCounts = led_counts;
  assign bus.data_v    = data_v_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_led_count_allocator.sv
// tb/tb_led_count_allocator.sv - randomized self-checking bench for led_count_allocator
module tb_led_count_allocator;
  localparam int W        = 6;
  localparam int D        = 10;
  localparam int LEDS     = 50;
  localparam int BIN_QTY  = 12;
  localparam int AW       = W + D;
  localparam int CW       = $clog2(LEDS);
  localparam int QB       = $clog2(LEDS + 1);
  localparam int FULL_LAT = BIN_QTY * (QB + 2) + 1;

  typedef logic [BIN_QTY-1:0][AW-1:0] amp_t;
  typedef logic [BIN_QTY-1:0][CW-1:0] cnt_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  led_count_allocator_if #(.W(W), .D(D), .LEDS(LEDS), .BIN_QTY(BIN_QTY)) bus ();

  led_count_allocator #(.W(W), .D(D), .LEDS(LEDS), .BIN_QTY(BIN_QTY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Proportional floor shares, leftover to the first loudest bin
  task automatic model(input amp_t a, output cnt_t c, output int lat, output int tot_out);
    longint s = 0;
    int     mi = 0;
    int     tot = 0;
    c = '0;
    for (int i = 0; i < BIN_QTY; i++) begin
      s += longint'(a[i]);
      if (a[i] > a[mi]) mi = i;
    end
    if (s == 0) begin
      lat = BIN_QTY;
      tot_out = 0;
    end else begin
      for (int i = 0; i < BIN_QTY; i++) begin
        c[i] = CW'(longint'(a[i]) * LEDS / s);
        tot += int'(c[i]);
      end
      c[mi] = c[mi] + CW'(LEDS - tot);
      lat = FULL_LAT;
      tot_out = LEDS;
    end
  endtask

  function automatic int count_sum();
    int s = 0;
    for (int i = 0; i < BIN_QTY; i++) s += int'(bus.LEDCounts[i]);
    return s;
  endfunction

  task automatic check_counts(input string tag, input cnt_t exp);
    for (int i = 0; i < BIN_QTY; i++)
      check($sformatf("%s bin%0d", tag, i), longint'(bus.LEDCounts[i]), longint'(exp[i]));
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < BIN_QTY; i++) bus.noteAmplitudes[i] = AW'($urandom);
  endtask

  task automatic wait_dv(input int limit, output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      #1;
    end while (!bus.data_v && edges < limit);
    if (!bus.data_v) edges = -1;
  endtask

  task automatic run(input string tag, input amp_t a);
    cnt_t exp;
    int   lat, tot, got_lat;
    model(a, exp, lat, tot);
    @(negedge clk);
    bus.noteAmplitudes = a;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    scramble_inputs();
    check({tag, " busy"}, longint'(bus.busy), 1);
    wait_dv(FULL_LAT + 20, got_lat);
    check({tag, " latency"}, longint'(got_lat), longint'(lat));
    check_counts(tag, exp);
    check({tag, " total"}, longint'(count_sum()), longint'(tot));
    @(posedge clk);
    #1;
    check({tag, " pulse"}, longint'(bus.data_v), 0);
    check({tag, " idle"}, longint'(bus.busy), 0);
    scramble_inputs();
    repeat (3) @(posedge clk);
    #1;
    check({tag, " hold"}, longint'(bus.LEDCounts == exp), 1);
  endtask

  initial begin
    amp_t   a;
    cnt_t   exp;
    int     lat, tot, pulses, first_edge;
    int     dv_edges[$];

    rst = 1'b0;
    bus.start = 1'b0;
    bus.noteAmplitudes = '0;
    #2;
    check("reset counts", longint'(count_sum()), 0);
    check("reset data_v", longint'(bus.data_v), 0);
    check("reset busy", longint'(bus.busy), 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < BIN_QTY; i++) a[i] = AW'(1024);
    run("uniform", a);
    a = '0; a[5] = AW'(500);
    run("single", a);
    a = '0; a[0] = AW'(3072); a[1] = AW'(1024);
    run("ratio", a);
    a = '0;
    run("zero", a);
    for (int i = 0; i < BIN_QTY; i++) a[i] = '1;
    run("full", a);

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < BIN_QTY; i++)
        a[i] = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
      run($sformatf("rand%0d", n), a);
    end

    // start held high: each run re-sampled two edges after data_v
    @(negedge clk);
    bus.noteAmplitudes = '0;
    bus.start = 1'b1;
    @(posedge clk);
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk);
      #1;
      if (bus.data_v) dv_edges.push_back(e);
    end
    bus.start = 1'b0;
    check("b2b runs", longint'(dv_edges.size()), 2);
    if (dv_edges.size() == 2) begin
      check("b2b first", longint'(dv_edges[0]), BIN_QTY);
      check("b2b second", longint'(dv_edges[1]), 2 * BIN_QTY + 2);
    end
    repeat (20) @(posedge clk);

    // start pulse mid-run is dropped, not queued
    for (int i = 0; i < BIN_QTY; i++) a[i] = AW'($urandom_range(1, 65535));
    model(a, exp, lat, tot);
    @(negedge clk);
    bus.noteAmplitudes = a;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    pulses = 0;
    first_edge = -1;
    for (int e = 1; e <= FULL_LAT + 60; e++) begin
      @(posedge clk);
      #1;
      if (e == 39) bus.start = 1'b1;
      if (e == 40) bus.start = 1'b0;
      if (bus.data_v) begin
        pulses++;
        if (first_edge < 0) first_edge = e;
      end
    end
    check("busy-start pulses", longint'(pulses), 1);
    check("busy-start latency", longint'(first_edge), FULL_LAT);
    check_counts("busy-start", exp);

    // asynchronous reset in the middle of DIV
    for (int i = 0; i < BIN_QTY; i++) a[i] = AW'($urandom_range(1, 65535));
    @(negedge clk);
    bus.noteAmplitudes = a;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (50) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("abort counts", longint'(count_sum()), 0);
    check("abort data_v", longint'(bus.data_v), 0);
    check("abort busy", longint'(bus.busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int e = 0; e < FULL_LAT + 20; e++) begin
      @(posedge clk);
      #1;
      if (bus.data_v) pulses++;
    end
    check("abort no data_v", longint'(pulses), 0);
    check("abort held zero", longint'(count_sum()), 0);
    for (int i = 0; i < BIN_QTY; i++) a[i] = AW'($urandom_range(0, 65535));
    run("post-reset", a);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_count_allocator.md
Name: led_count_allocator

Overview:
- Upstream stage of the LED serial driver. It turns per-bin note amplitudes into per-bin LED counts that always total exactly LEDS, or zero when there is no signal.
- Counts are proportional to each bin's share of total amplitude. Rounding leftovers go to the loudest bin.
- Sits beside the colour path. Its LEDCounts vector and data_v pulse feed the driver's LEDCounts and start inputs.

Parameters:
W, 6, integer bits of amplitude fixed-point
D, 10, fractional bits of amplitude fixed-point
LEDS, 50, LEDs to distribute; must satisfy LEDS < 2**$clog2(LEDS)
BIN_QTY, 12, number of note bins
QB (localparam), $clog2(LEDS+1), quotient bits per bin

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
start  input  1  request new allocation; sampled only in IDLE
noteAmplitudes  input  [BIN_QTY-1:0][W+D-1:0]  unsigned amplitudes
LEDCounts  output  [BIN_QTY-1:0][$clog2(LEDS)-1:0]  LEDs per bin, registered
data_v  output  1  one-cycle pulse: LEDCounts updated
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst low, async): state IDLE; LEDCounts all 0; data_v 0; busy 0; working registers cleared. Reset mid-operation aborts the allocation. No data_v is produced for it.
- States: IDLE, SUM, DIV, FIX, DONE.
- IDLE:
  - On start=1, snapshot noteAmplitudes into internal registers, clear the accumulator and max tracker, go to SUM.
  - Input changes after the snapshot are ignored.
- SUM (BIN_QTY cycles, one bin per cycle, index 0 upward):
  - sum += amp[i]; sum width is W+D+$clog2(BIN_QTY), with no overflow.
  - Track maxIdx = index of the largest amplitude; ties go to the lowest index.
  - After the last bin: go to DONE with working counts all 0 if sum==0, otherwise go to DIV.
- DIV (per bin: 1 load cycle + QB iterate cycles = QB+1 cycles):
  - Restoring divider: cnt[i] = floor(amp[i]*LEDS / sum).
  - Numerator width is W+D+QB. One quotient bit is produced per cycle, MSB first.
  - A running total of cnt is kept, width QB+$clog2(BIN_QTY).
- FIX (1 cycle):
  - cnt[maxIdx] += LEDS - total.
  - The remainder is in 0..BIN_QTY-1. The result is ≤ LEDS and fits the output width.
- DONE (1 cycle): LEDCounts <= cnt; data_v=1; next state IDLE.
- Latency: counting the start-sampling edge as edge 0, DONE (and data_v) is entered at edge BIN_QTY*(QB+2)+1, which is 97 with the default parameters. For sum==0 it is entered at edge BIN_QTY=12.
- LEDCounts holds its value from one DONE to the next. It never changes at any other time.
- start while busy: ignored, not queued. start held high continuously produces back-to-back runs, each re-sampled in IDLE.
- Output invariant: sum of LEDCounts == LEDS, or all counts 0 when every amplitude is 0.

Test Plan:
- Reset: assert rst low mid-cycle, asynchronously -> LEDCounts all 0, data_v 0, busy 0 immediately, without waiting for a clock edge.
- All 12 amplitudes 1024 (1.0), start -> data_v at edge 97; bin0=6, bins1-11=4 (floors of 4, remainder 2 to lowest-index max); sum 50.
- Only bin5=500 -> bin5=50, all others 0; data_v at edge 97.
- bin0=3072, bin1=1024, rest 0 -> floors 37 and 12, remainder 1 to bin0 -> bin0=38, bin1=12, others 0.
- All amplitudes 0 -> data_v at edge 12, LEDCounts all 0, busy drops the cycle after.
- start pulsed at edge 40 of a run, then rst low during DIV -> first run: exactly one data_v, and the edge-40 pulse causes no second run. After reset: no data_v, counts 0; a fresh start then completes normally.
